// File: rtl/wb_interface_master.sv
// Wishbone B4 classic-cycle bus master.
// Turns a command/data-stream request from the SDIO DMA data path into single or
// incrementing-burst Wishbone cycles, and reports completion and error status.
// Optional build macro WB_MASTER_TIMEOUT_EN adds a 16-bit response watchdog in BUS.
// DATA_WIDTH is expected to be 8, 16, 32 or 64.

module wb_interface_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned MAX_RETRY  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // Command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_adr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  // Write data stream
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // Read data stream and status
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  error,
  // Wishbone master side
  output logic [DATA_WIDTH-1:0] dat_m2s,
  output logic [ADDR_WIDTH-1:0] adr_m2s,
  output logic                  cyc_m2s,
  output logic                  stb_m2s,
  output logic                  we_m2s,
  output logic [2:0]            cti_m2s,
  output logic [1:0]            bte_m2s,
  input  logic [DATA_WIDTH-1:0] dat_s2m,
  input  logic                  ack_s2m,
  input  logic                  err_s2m,
  input  logic                  rty_s2m
);

  // Retry counter must hold MAX_RETRY + 1 (the value that triggers the abort).
  localparam int unsigned RetryWidth = $clog2(MAX_RETRY + 2);
  localparam logic [ADDR_WIDTH-1:0] AdrStep = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [RetryWidth-1:0] RetryLimit = RetryWidth'(MAX_RETRY);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWdata = 3'd1;
  localparam logic [2:0] StBus   = 3'd2;
  localparam logic [2:0] StRetry = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEnd     = 3'b111;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  we_q, we_d;
  logic                  burst_q, burst_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [RetryWidth-1:0] retry_q, retry_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  last_beat;

  assign last_beat = (beats_q == LEN_WIDTH'(1));

`ifdef WB_MASTER_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        wd_expired;

  assign wd_expired = (wd_q == 16'hFFFF);

  // Watchdog counts silent BUS cycles; any response or any other state clears it.
  always_comb begin
    wd_d = '0;
    if (state_q == StBus && !(ack_s2m || err_s2m || rty_s2m)) begin
      wd_d = wd_q + 16'd1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  // Next-state and datapath update for the command FSM.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    burst_d    = burst_q;
    beats_d    = beats_q;
    retry_d    = retry_q;
    error_d    = error_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          we_d    = cmd_we;
          // A zero length is a single beat.
          beats_d = (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
          burst_d = (cmd_len > LEN_WIDTH'(1));
          retry_d = '0;
          error_d = 1'b0;
          state_d = cmd_we ? StWdata : StBus;
        end
      end

      StWdata: begin
        if (wr_valid) begin
          dat_d   = wr_data;
          state_d = StBus;
        end
      end

      StBus: begin
        // err wins over a simultaneous ack.
        if (err_s2m) begin
          error_d = 1'b1;
          state_d = StDone;
        end else if (ack_s2m) begin
          if (!we_q) begin
            rd_data_d  = dat_s2m;
            rd_valid_d = 1'b1;
          end
          adr_d   = adr_q + AdrStep;
          beats_d = beats_q - LEN_WIDTH'(1);
          retry_d = '0;
          if (last_beat) begin
            state_d = StDone;
          end else begin
            state_d = we_q ? StWdata : StBus;
          end
        end else if (rty_s2m) begin
          retry_d = retry_q + RetryWidth'(1);
          if (retry_q >= RetryLimit) begin
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRetry;
          end
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (wd_expired) begin
          error_d = 1'b1;
          state_d = StDone;
        end
`endif
      end

      // One idle strobe cycle, then the same beat is presented again.
      StRetry: state_d = StBus;

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      burst_q    <= 1'b0;
      beats_q    <= '0;
      retry_q    <= '0;
      error_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      burst_q    <= burst_d;
      beats_q    <= beats_d;
      retry_q    <= retry_d;
      error_q    <= error_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Bus and handshake outputs decoded from the state; reset drops them at once.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    wr_ready  = (state_q == StWdata);
    cyc_m2s   = (state_q == StWdata) || (state_q == StBus) || (state_q == StRetry);
    stb_m2s   = (state_q == StBus);
    we_m2s    = cyc_m2s && we_q;
    adr_m2s   = adr_q;
    dat_m2s   = dat_q;
    bte_m2s   = 2'b00;
    cti_m2s   = CtiClassic;
    if (stb_m2s && burst_q) begin
      cti_m2s = last_beat ? CtiEnd : CtiIncr;
    end
    done      = (state_q == StDone);
    error     = done && error_q;
    rd_data   = rd_data_q;
    rd_valid  = rd_valid_q;
  end

endmodule

// File: doc/wb_interface_master.md
Name: wb_interface_master

Overview:
- Wishbone B4 classic-cycle bus master; the initiator counterpart of the SDIO controller's Wishbone slave interface.
- Converts a simple command/data-stream request from the SDIO data path (DMA side) into single or incrementing-burst Wishbone cycles.
- Handles ack, err and rty responses.
- Reports completion and error status back to the requester.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; must be 8, 16, 32 or 64.
- LEN_WIDTH, 8, width of the burst beat-count field.
- MAX_RETRY, 4, number of rty responses tolerated per beat before the command aborts with error.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready; cmd_ready = (state == IDLE).
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  ADDR_WIDTH  start byte address, aligned to DATA_WIDTH/8.
- cmd_len  in  LEN_WIDTH  number of beats; 0 is treated as 1.
- wr_data  in  DATA_WIDTH  write data stream.
- wr_valid  in  1  write data valid.
- wr_ready  out  1  write data consumed when wr_valid & wr_ready.
- rd_data  out  DATA_WIDTH  read data; registered.
- rd_valid  out  1  one-cycle pulse per read beat; no backpressure.
- done  out  1  one-cycle pulse at command end.
- error  out  1  valid with done; 1 = err response or retry limit hit.
- dat_m2s  out  DATA_WIDTH  Wishbone write data.
- adr_m2s  out  ADDR_WIDTH  Wishbone address.
- cyc_m2s, stb_m2s, we_m2s  out  1 each  Wishbone cycle, strobe and write-enable.
- cti_m2s  out  3  cycle type identifier.
- bte_m2s  out  2  burst type extension; always 2'b00 (linear).
- dat_s2m  in  DATA_WIDTH  Wishbone read data.
- ack_s2m, err_s2m, rty_s2m  in  1 each  slave responses.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - cyc/stb/we/rd_valid/done/error/wr_ready = 0.
  - adr/dat/rd_data = 0, cti = 0, bte = 0.
  - Beat counter and retry counter cleared.
  - Reset asserted mid-cycle drops cyc immediately; the command is lost and no done is issued.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch adr, we and beats = max(cmd_len, 1); cyc_m2s <= 1.
  - Next state is WDATA if write, else BUS.
- WDATA:
  - stb = 0, cyc held, wr_ready = 1.
  - On wr_valid: dat_m2s <= wr_data, wr_ready drops, go to BUS.
  - No timeout while waiting for data.
- BUS:
  - stb = 1, we = latched direction.
  - cti = 3'b000 if beats == 1 at accept (single access).
  - Otherwise cti = 3'b010, becoming 3'b111 on the final beat.
  - Responses are sampled in priority order err > ack > rty.
  - ack:
    - Read: rd_data <= dat_s2m and rd_valid pulse on the next cycle.
    - adr += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
    - Beats decrement; retry counter clears.
    - If beats remain: reads stay in BUS (back-to-back, stb kept high); writes go to WDATA.
    - Last beat: go to DONE.
  - err: abort; go to DONE with error = 1.
  - rty: increment retry counter.
    - If it exceeds MAX_RETRY: go to DONE with error = 1.
    - Otherwise go to RETRY.
- RETRY:
  - One cycle with stb = 0 and cyc held.
  - Then back to BUS with the same adr and dat (same beat re-presented).
- DONE:
  - cyc = stb = 0, cti = 0.
  - done pulses for 1 cycle; error holds its value in that same cycle only.
  - Returns to IDLE; the earliest next accept is the cycle after done.
- Timing:
  - Single read latency from accept to rd_valid = 2 cycles + slave wait states.
  - done occurs 1 cycle after the final ack.
- Bus-rule boundaries:
  - Simultaneous ack and err: treated as err.
  - Responses arriving with stb low are ignored.
  - A new cmd_valid during a command is not accepted (cmd_ready = 0).

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - 16-bit watchdog counts cycles in BUS with no ack, err or rty.
  - At 16'hFFFF the command aborts as for err: done pulse with error = 1, cyc dropped.
  - Watchdog clears on any response and in every other state.
- Undefined: no watchdog; the master waits indefinitely for a response.

Test Plan:
1. Single write: adr 0x10, len 1, data 32'hFFFF_FFFF; slave acks after 1 wait state.
   -> One stb cycle, cti 000, we 1, done with error 0; wr_ready handshake occurs exactly once.
2. Read burst: adr 0x100, len 4; slave returns 0xA0..0xA3 with zero wait.
   -> adr sequence 0x100/0x104/0x108/0x10C; cti 010,010,010,111; 4 rd_valid pulses in order; stb never drops; done 1 cycle after the last ack.
3. Write burst of 3 with wr_valid stalled 5 cycles before beat 2.
   -> cyc stays 1, stb 0 during the stall, data beats in order, done error 0.
4. Retry:
   - Slave asserts rty twice, then acks -> same adr/dat re-presented with a 1-cycle stb gap, done error 0.
   - Slave asserts rty MAX_RETRY+1 times -> done with error 1 and cyc dropped.
5. err on beat 2 of a 4-beat read -> exactly 1 rd_valid, done with error 1, cyc 0 the following cycle.
6. rst driven low mid-burst (beat 2 of 4) -> cyc/stb go to 0 asynchronously with no done; after release, a new len-1 read completes normally.
